// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, memop encodings, EX/MEM payload type
// Purpose: widths and encodings shared by the pipeline stages, plus the packed
//          EX/MEM payload bundle and the skid-buffer state type.
// Ports:   none (package)
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int MEMOP_W    = 3;

    // funct3 access size/sign codes; loads and stores share the size encoding
    localparam logic [MEMOP_W-1:0] MEMOP_LB  = 3'b000;
    localparam logic [MEMOP_W-1:0] MEMOP_LH  = 3'b001;
    localparam logic [MEMOP_W-1:0] MEMOP_LW  = 3'b010;
    localparam logic [MEMOP_W-1:0] MEMOP_LBU = 3'b100;
    localparam logic [MEMOP_W-1:0] MEMOP_LHU = 3'b101;
    localparam logic [MEMOP_W-1:0] MEMOP_SB  = 3'b000;
    localparam logic [MEMOP_W-1:0] MEMOP_SH  = 3'b001;
    localparam logic [MEMOP_W-1:0] MEMOP_SW  = 3'b010;

    typedef struct packed {
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       store_data;
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_we;
        logic                  mem_rd;
        logic                  mem_wr;
        logic [MEMOP_W-1:0]    memop;
    } ex_mem_payload_t;

    localparam int EX_MEM_PAYLOAD_W = $bits(ex_mem_payload_t);

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic 2-entry valid/ready skid buffer with flush
// Purpose: full-throughput register slice whose in_ready comes straight from a flop.
// Ports:   clk, reset_n (async active-low), flush (sync kill of all beats),
//          in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data
//          (downstream, out_data is the main register).
module pipe_skid_buf
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             accept;
    logic             drain;

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // payload registers keep their stale contents; only validity is killed
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = SKID_BUSY;
                    end
                end
                SKID_BUSY: begin
                    if (accept && drain) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = SKID_FULL;
                    end else if (drain) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    // in_ready is low here, so no accept can collide with promotion
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = SKID_BUSY;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
        in_ready_d  = (state_d != SKID_FULL);
        out_valid_d = (state_d != SKID_EMPTY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SKID_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/ex_mem_skid_stage.sv
// rtl/ex_mem_skid_stage.sv - execute->memory pipeline stage over a skid buffer
// Purpose: captures ALU result, store data, PC, rd and mem/wb controls and hands
//          them to the memory stage with valid/ready at 1 beat/cycle.
// Ports:   clk, reset_n (async active-low), flush; in_valid/in_ready + in_* payload
//          from execute; out_valid/out_ready + out_* payload to memory stage.
module ex_mem_skid_stage
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [XLEN-1:0]       in_store_data,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_we,
    input  logic                  in_mem_rd,
    input  logic                  in_mem_wr,
    input  logic [MEMOP_W-1:0]    in_memop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_alu_result,
    output logic [XLEN-1:0]       out_store_data,
    output logic [XLEN-1:0]       out_pc,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_we,
    output logic                  out_mem_rd,
    output logic                  out_mem_wr,
    output logic [MEMOP_W-1:0]    out_memop
);

    ex_mem_payload_t in_payload;
    ex_mem_payload_t out_payload;

    always_comb begin
        in_payload            = '0;
        in_payload.alu_result = in_alu_result;
        in_payload.store_data = in_store_data;
        in_payload.pc         = in_pc;
        in_payload.rd         = in_rd;
        // x0 is hardwired, so a write to it is dropped here rather than in writeback
        in_payload.reg_we     = in_reg_we & (in_rd != '0);
        in_payload.mem_rd     = in_mem_rd;
        in_payload.mem_wr     = in_mem_wr;
        in_payload.memop      = in_memop;
    end

    pipe_skid_buf #(
        .WIDTH(EX_MEM_PAYLOAD_W)
    ) u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_payload)
    );

    assign out_alu_result = out_payload.alu_result;
    assign out_store_data = out_payload.store_data;
    assign out_pc         = out_payload.pc;
    assign out_rd         = out_payload.rd;
    assign out_reg_we     = out_payload.reg_we;
    assign out_mem_rd     = out_payload.mem_rd;
    assign out_mem_wr     = out_payload.mem_wr;
    assign out_memop      = out_payload.memop;

    a_no_load_store: assert property (@(posedge clk) disable iff (!reset_n)
        in_valid |-> !(in_mem_rd && in_mem_wr));

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// tb/tb_ex_mem_skid_stage.sv - self-checking bench for ex_mem_skid_stage
module tb_ex_mem_skid_stage;
    import cpu_pkg::*;

    logic                  clk;
    logic                  reset_n;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [XLEN-1:0]       in_alu_result;
    logic [XLEN-1:0]       in_store_data;
    logic [XLEN-1:0]       in_pc;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_reg_we;
    logic                  in_mem_rd;
    logic                  in_mem_wr;
    logic [MEMOP_W-1:0]    in_memop;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_alu_result;
    logic [XLEN-1:0]       out_store_data;
    logic [XLEN-1:0]       out_pc;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_reg_we;
    logic                  out_mem_rd;
    logic                  out_mem_wr;
    logic [MEMOP_W-1:0]    out_memop;

    ex_mem_skid_stage dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_alu_result (in_alu_result),
        .in_store_data (in_store_data),
        .in_pc         (in_pc),
        .in_rd         (in_rd),
        .in_reg_we     (in_reg_we),
        .in_mem_rd     (in_mem_rd),
        .in_mem_wr     (in_mem_wr),
        .in_memop      (in_memop),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_result(out_alu_result),
        .out_store_data(out_store_data),
        .out_pc        (out_pc),
        .out_rd        (out_rd),
        .out_reg_we    (out_reg_we),
        .out_mem_rd    (out_mem_rd),
        .out_mem_wr    (out_mem_wr),
        .out_memop     (out_memop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Model: the beats held by the stage, oldest first. Head is what OUT_* must show.
    ex_mem_payload_t model_q[$];
    logic [XLEN-1:0] log_alu[$];
    int              log_cyc[$];

    ex_mem_payload_t dut_out;
    assign dut_out = {out_alu_result, out_store_data, out_pc, out_rd,
                      out_reg_we, out_mem_rd, out_mem_wr, out_memop};

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic checkp(input string name, input ex_mem_payload_t act, input ex_mem_payload_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_q.delete();
        end else begin
            bit accept;
            bit drain;
            ex_mem_payload_t beat;
            cycle++;
            accept = in_valid && (model_q.size() < 2);
            drain  = (model_q.size() != 0) && out_ready;
            beat.alu_result = in_alu_result;
            beat.store_data = in_store_data;
            beat.pc         = in_pc;
            beat.rd         = in_rd;
            beat.reg_we     = in_reg_we && (in_rd != 0);
            beat.mem_rd     = in_mem_rd;
            beat.mem_wr     = in_mem_wr;
            beat.memop      = in_memop;
            if (flush) begin
                model_q.delete();
            end else begin
                if (drain) void'(model_q.pop_front());
                if (accept) model_q.push_back(beat);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            check1("rst_out_valid", 32'(out_valid), 32'd0);
            check1("rst_in_ready", 32'(in_ready), 32'd1);
            checkp("rst_payload", dut_out, '0);
        end else begin
            check1("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
            check1("in_ready", 32'(in_ready), 32'(model_q.size() < 2));
            if (model_q.size() != 0) checkp("payload", dut_out, model_q[0]);
            if (out_valid && out_ready) begin
                log_alu.push_back(out_alu_result);
                log_cyc.push_back(cycle);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [4:0] rd, input logic we);
        in_valid      = 1'b1;
        in_alu_result = alu;
        in_store_data = alu ^ 32'hFFFF_0000;
        in_pc         = alu << 2;
        in_rd         = rd;
        in_reg_we     = we;
        in_mem_rd     = 1'b1;
        in_mem_wr     = 1'b0;
        in_memop      = MEMOP_LW;
    endtask

    initial begin
        reset_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(32'h55, 5'd3, 1'b1);

        // 1. reset with in_valid held high
        step(); step(); step();
        check1("t1_rst_valid", 32'(out_valid), 32'd0);
        check1("t1_rst_ready", 32'(in_ready), 32'd1);
        check1("t1_rst_alu", out_alu_result, 32'd0);
        reset_n = 1'b1;
        drive(32'h1, 5'd3, 1'b1);
        step();
        in_valid = 1'b0;
        check1("t1_first_valid", 32'(out_valid), 32'd1);
        check1("t1_first_alu", out_alu_result, 32'h1);
        out_ready = 1'b1;
        step();

        // 2. streaming
        log_alu.delete(); log_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            check1("t2_in_ready", 32'(in_ready), 32'd1);
            drive(32'h100 + 32'(i), 5'd4, 1'b1);
            step();
        end
        in_valid = 1'b0;
        step(); step();
        check1("t2_count", 32'(log_alu.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_alu.size(); i++) begin
            check1("t2_alu", log_alu[i], 32'h100 + 32'(i));
            check1("t2_consecutive", 32'(log_cyc[i] - log_cyc[0]), 32'(i));
        end

        // 3. backpressure
        out_ready = 1'b0;
        log_alu.delete(); log_cyc.delete();
        drive(32'hA, 5'd1, 1'b1); step();
        drive(32'hB, 5'd2, 1'b1); step();
        in_valid = 1'b0;
        check1("t3_hold_alu", out_alu_result, 32'hA);
        check1("t3_full_ready", 32'(in_ready), 32'd0);
        step();
        check1("t3_stable_alu", out_alu_result, 32'hA);
        out_ready = 1'b1;
        step(); step(); step();
        check1("t3_count", 32'(log_alu.size()), 32'd2);
        if (log_alu.size() == 2) begin
            check1("t3_first", log_alu[0], 32'hA);
            check1("t3_second", log_alu[1], 32'hB);
        end
        check1("t3_ready_after", 32'(in_ready), 32'd1);

        // 4. flush while full with a simultaneous offer
        out_ready = 1'b0;
        drive(32'h1A, 5'd1, 1'b1); step();
        drive(32'h1B, 5'd1, 1'b1); step();
        drive(32'hC, 5'd1, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check1("t4_valid", 32'(out_valid), 32'd0);
        check1("t4_ready", 32'(in_ready), 32'd1);
        log_alu.delete(); log_cyc.delete();
        out_ready = 1'b1;
        step(); step(); step();
        check1("t4_nothing_out", 32'(log_alu.size()), 32'd0);

        // 5. rd==0 write filter
        out_ready = 1'b0;
        drive(32'hDEADBEEF, 5'd0, 1'b1); step();
        in_valid = 1'b0;
        check1("t5_valid", 32'(out_valid), 32'd1);
        check1("t5_reg_we", 32'(out_reg_we), 32'd0);
        check1("t5_alu", out_alu_result, 32'hDEADBEEF);
        out_ready = 1'b1; step();
        out_ready = 1'b0;
        drive(32'h55, 5'd5, 1'b1); step();
        in_valid = 1'b0;
        check1("t5_reg_we_rd5", 32'(out_reg_we), 32'd1);
        check1("t5_rd", 32'(out_rd), 32'd5);
        out_ready = 1'b1; step();

        // 6. random valid/ready/flush traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int op;
            in_valid      = 1'($urandom_range(0, 1));
            out_ready     = 1'($urandom_range(0, 1));
            flush         = ($urandom_range(0, 39) == 0);
            in_alu_result = $urandom();
            in_store_data = $urandom();
            in_pc         = $urandom();
            in_rd         = 5'($urandom_range(0, 31));
            in_reg_we     = 1'($urandom_range(0, 1));
            in_memop      = 3'($urandom_range(0, 7));
            op            = int'($urandom_range(0, 2));
            in_mem_rd     = (op == 1);
            in_mem_wr     = (op == 2);
            step();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        step(); step(); step();
        check1("t6_drained", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
